// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, field offsets, NOP payload and slot ops for pipe_reg
package pipe_pkg;

    localparam int DATA_W_DEF = 160;
    localparam int CHK_W_DEF  = 1;

    // Payload layout: five 32-bit fields packed from the LSB upward.
    localparam int FIELD_W   = 32;
    localparam int INSTR_LSB = 0;
    localparam int PC_LSB    = 32;
    localparam int ALU_LSB   = 64;
    localparam int DM_LSB    = 96;
    localparam int IMM_LSB   = 128;

    localparam logic [DATA_W_DEF-1:0] NOP_PAYLOAD = '0;

    typedef enum logic [1:0] {
        SLOT_HOLD  = 2'd0,
        SLOT_LOAD  = 2'd1,
        SLOT_CLEAR = 2'd2
    } slot_op_t;

    function automatic logic [DATA_W_DEF-1:0] pack_fields(
        input logic [FIELD_W-1:0] instr,
        input logic [FIELD_W-1:0] pc,
        input logic [FIELD_W-1:0] alu,
        input logic [FIELD_W-1:0] dm,
        input logic [FIELD_W-1:0] imm
    );
        logic [DATA_W_DEF-1:0] p;
        p = NOP_PAYLOAD;
        p[INSTR_LSB +: FIELD_W] = instr;
        p[PC_LSB    +: FIELD_W] = pc;
        p[ALU_LSB   +: FIELD_W] = alu;
        p[DM_LSB    +: FIELD_W] = dm;
        p[IMM_LSB   +: FIELD_W] = imm;
        return p;
    endfunction

endpackage

// File: rtl/pipe_reg_slot.sv
// rtl/pipe_reg_slot.sv - one pipeline entry: valid + payload + check flops with load/clear
// A cleared or reset slot always holds the NOP payload, so downstream sees zero bubbles.
module pipe_reg_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CHK_W  = CHK_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  slot_op_t          op,
    input  logic [DATA_W-1:0] next_data,
    input  logic [CHK_W-1:0]  next_check,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CHK_W-1:0]  check
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= DATA_W'(NOP_PAYLOAD);
            check <= '0;
        end else begin
            case (op)
                SLOT_LOAD: begin
                    valid <= 1'b1;
                    data  <= next_data;
                    check <= next_check;
                end
                SLOT_CLEAR: begin
                    valid <= 1'b0;
                    data  <= DATA_W'(NOP_PAYLOAD);
                    check <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pipe_reg.sv
// rtl/pipe_reg.sv - valid/ready pipeline register; PIPE_REG_SKID_EN adds a second (skid) entry
// With the skid entry, in_ready comes straight from a flop to break the out_ready->in_ready path.
module pipe_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CHK_W  = CHK_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CHK_W-1:0]  in_check,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CHK_W-1:0]  out_check,
    output logic [1:0]        occ
);

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [CHK_W-1:0]  main_check;
    slot_op_t          main_op;
    logic              accept;
    logic              consume;

    assign accept    = in_valid && in_ready;
    assign consume   = main_valid && out_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_check = main_check;

`ifdef PIPE_REG_SKID_EN
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CHK_W-1:0]  skid_check;
    slot_op_t          skid_op;
    logic              main_from_skid;
    logic [DATA_W-1:0] main_next_data;
    logic [CHK_W-1:0]  main_next_check;

    assign in_ready = !skid_valid;
    assign occ      = {1'b0, main_valid} + {1'b0, skid_valid};

    // The skid entry is only ever occupied while main is occupied, so main is always the head.
    always_comb begin
        main_op        = SLOT_HOLD;
        skid_op        = SLOT_HOLD;
        main_from_skid = 1'b0;
        if (flush) begin
            main_op = SLOT_CLEAR;
            skid_op = SLOT_CLEAR;
        end else if (skid_valid) begin
            if (consume) begin
                main_op        = SLOT_LOAD;
                main_from_skid = 1'b1;
                skid_op        = SLOT_CLEAR;
            end
        end else if (!main_valid || consume) begin
            if (accept) begin
                main_op = SLOT_LOAD;
            end else if (consume) begin
                main_op = SLOT_CLEAR;
            end
        end else if (accept) begin
            skid_op = SLOT_LOAD;
        end
    end

    assign main_next_data  = main_from_skid ? skid_data  : in_data;
    assign main_next_check = main_from_skid ? skid_check : in_check;

    pipe_reg_slot #(
        .DATA_W (DATA_W),
        .CHK_W  (CHK_W)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .op         (skid_op),
        .next_data  (in_data),
        .next_check (in_check),
        .valid      (skid_valid),
        .data       (skid_data),
        .check      (skid_check)
    );
`else
    logic [DATA_W-1:0] main_next_data;
    logic [CHK_W-1:0]  main_next_check;

    assign in_ready        = !main_valid || out_ready;
    assign occ             = {1'b0, main_valid};
    assign main_next_data  = in_data;
    assign main_next_check = in_check;

    always_comb begin
        main_op = SLOT_HOLD;
        if (flush) begin
            main_op = SLOT_CLEAR;
        end else if (accept) begin
            main_op = SLOT_LOAD;
        end else if (consume) begin
            main_op = SLOT_CLEAR;
        end
    end
`endif

    pipe_reg_slot #(
        .DATA_W (DATA_W),
        .CHK_W  (CHK_W)
    ) u_main (
        .clk        (clk),
        .reset      (reset),
        .op         (main_op),
        .next_data  (main_next_data),
        .next_check (main_next_check),
        .valid      (main_valid),
        .data       (main_data),
        .check      (main_check)
    );

endmodule

// File: tb/tb_pipe_reg.sv
// tb/tb_pipe_reg.sv - self-checking bench for pipe_reg against a queue model
module tb_pipe_reg;
    import pipe_pkg::*;

    localparam int DW = DATA_W_DEF;
    localparam int CW = CHK_W_DEF;
`ifdef PIPE_REG_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_check = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_check;
    logic [1:0]    occ;

    logic [DW+CW-1:0] q[$];
    int n_vec = 0;
    int n_miss = 0;

    pipe_reg #(.DATA_W(DW), .CHK_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_check  (in_check),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_check (out_check),
        .occ       (occ)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < (DW + 31) / 32; i++) r = (r << 32) | DW'($urandom);
        return r;
    endfunction

    // Drive one cycle, compare against the model mid-cycle, then advance the model at posedge.
    task automatic step(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input logic ordy, input logic fl);
        logic             exp_ready;
        logic [DW+CW-1:0] head;
        int               n;
        @(negedge clk);
        in_valid = iv; in_data = d; in_check = c; out_ready = ordy; flush = fl;
        #1;
        n = q.size();
        head = (n > 0) ? q[0] : '0;
        exp_ready = SKID ? (n < 2) : (n == 0 || ordy);
        check("out_valid", DW'(out_valid), DW'(n > 0));
        check("out_data", out_data, head[DW+CW-1:CW]);
        check("out_check", DW'(out_check), DW'(head[CW-1:0]));
        check("occ", DW'(occ), DW'(n));
        check("in_ready", DW'(in_ready), DW'(exp_ready));
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (ordy && n > 0) void'(q.pop_front());
            if (iv && exp_ready) q.push_back({d, c});
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_data = '0; in_check = '0; out_ready = 1'b0; flush = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] a, b, c;
        #1;
        check("reset out_valid", DW'(out_valid), '0);
        check("reset out_data", out_data, '0);
        check("reset occ", DW'(occ), '0);
        @(negedge clk);
        reset = 1'b0;

        step(1'b1, DW'(pack_fields(32'h0AB, '0, '0, '0, '0)), 1'b1, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), CW'(i), 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        a = rnd_data(); b = rnd_data(); c = rnd_data();
        step(1'b1, a, 1'b0, 1'b0, 1'b0);
        step(1'b1, b, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        step(1'b1, a, 1'b0, 1'b0, 1'b0);
        step(1'b1, b, 1'b1, 1'b0, 1'b0);
        step(1'b1, c, 1'b1, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

`ifndef PIPE_REG_SKID_EN
        step(1'b1, a, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        #1;
        check("stall in_ready", DW'(in_ready), '0);
        out_ready = 1'b1;
        #1;
        check("comb in_ready", DW'(in_ready), DW'(1));
        check("comb out_data", out_data, a);
        @(posedge clk);
        void'(q.pop_front());
`endif

        step(1'b1, a, 1'b1, 1'b0, 1'b0);
        step(1'b1, b, 1'b1, 1'b0, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        check("async out_valid", DW'(out_valid), '0);
        check("async out_data", out_data, '0);
        check("async out_check", DW'(out_check), '0);
        check("async occ", DW'(occ), '0);
        q.delete();
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, '0, '0, 1'b1, 1'b0);

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) != 0), rnd_data(), CW'($urandom),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 31) == 0));
        end
        repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pipe_reg.md
PIPE_REG -- requirements
Module: pipe_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 160, meaning payload width (instr, PC, ALU result, DM data, imm32, five 32-bit fields).
REQ-002 SHALL have parameter CHK_W, default 1, meaning sideband check/flag width.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on posedge.
REQ-004 SHALL have port reset, input, 1, meaning asynchronous, active-high reset.
REQ-005 SHALL have port flush, input, 1, meaning synchronous squash of all held entries.
REQ-006 SHALL have port in_valid, input, 1, meaning upstream stage offers an entry.
REQ-007 SHALL have port in_ready, output, 1, meaning this stage accepts an entry this cycle.
REQ-008 SHALL have port in_data, input, DATA_W, meaning upstream payload.
REQ-009 SHALL have port in_check, input, CHK_W, meaning upstream sideband flags.
REQ-010 SHALL have port out_valid, output, 1, meaning held entry presented downstream.
REQ-011 SHALL have port out_ready, input, 1, meaning downstream consumes this cycle.
REQ-012 SHALL have port out_data, output, DATA_W, meaning registered payload.
REQ-013 SHALL have port out_check, output, CHK_W, meaning registered sideband flags.
REQ-014 SHALL have port occ, output, 2, meaning entries held (0..2).

Function
REQ-015 SHALL treat in_valid&&in_ready as accept and out_valid&&out_ready as consume, both at the same posedge.
REQ-016 SHALL present an accepted entry on out_* exactly 1 cycle after acceptance when empty.
REQ-017 SHALL drive out_data and out_check to all-zero (NOP bubble) whenever out_valid=0.
REQ-018 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-019 SHALL preserve order; no entry dropped or duplicated except via flush.
REQ-020 SHALL support simultaneous accept and consume at full rate, one entry per cycle, with occ unchanged.
REQ-021 SHALL, on flush=1, at the next posedge clear all entries (occ=0, out_valid=0, data zero) and discard any entry accepted that cycle; flush has priority over accept and consume.
REQ-022 SHALL ignore in_data/in_check when in_valid=0.
REQ-023 SHALL keep occ consistent: occ = out_valid + skid_valid.

Reset
REQ-024 SHALL, while reset=1, asynchronously force out_valid=0, out_data=0, out_check=0, occ=0, skid contents zero.
REQ-025 SHALL drive in_ready=1 one cycle after reset deasserts (no entries held).
REQ-026 SHALL abandon any in-flight entry on reset mid-operation; no partial state survives.

Configuration
REQ-027 SHALL compile a 2-entry skid buffer when PIPE_REG_SKID_EN is defined: in_ready = !skid_valid, driven from a flop (no out_ready-to-in_ready combinational path); accept while main full and out_ready=0 fills skid; consume with skid full moves skid to main and in_ready returns 1 next cycle.
REQ-028 SHALL, without PIPE_REG_SKID_EN, hold one entry: in_ready = !out_valid || out_ready (combinational); occ never exceeds 1.

Structure
REQ-029 SHALL take from shared package pipe_pkg: default widths, field LSB offsets (INSTR, PC, ALU, DM, IMM), NOP payload constant.
REQ-030 SHALL build storage from sub-module pipe_reg_slot (data+check+valid flop with load/clear), instantiated once or twice per configuration.

Verification
REQ-031 SHALL cover: reset, then in_valid=1 data=0x...0AB, out_ready=1 -> out_valid=1 data=0x...0AB next cycle, occ=1.
REQ-032 SHALL cover: streaming 8 entries 1..8 with out_ready=1 -> outputs 1..8 consecutive cycles, in_ready always 1.
REQ-033 SHALL cover (SKID_EN): out_ready=0, send A,B -> occ=2, in_ready=0, out_data=A held; out_ready=1 -> A then B, in_ready=1 one cycle after A consumed.
REQ-034 SHALL cover: occ=2, flush=1 with in_valid=1 data C -> next cycle occ=0, out_valid=0, out_data=0; C never appears.
REQ-035 SHALL cover: reset asserted mid-stream between clock edges -> outputs zero immediately, before next posedge.
REQ-036 SHALL cover (no SKID_EN): out_valid=1, out_ready=0 -> in_ready=0; out_ready=1 same cycle -> in_ready=1 combinationally.
